// File: rtl/reaction_timer.sv
// Reaction-time game core: random wait, GO lamp, millisecond reaction count with saturation.
// Optional best-score register enabled by defining REACTION_BEST_EN.
module reaction_timer #(
    parameter int unsigned BASE_DELAY_MS = 1000,
    parameter int unsigned MAX_MS        = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    output logic        led_go,
    output logic [13:0] ms_count,
    output logic        early,
    output logic        timeout,
`ifdef REACTION_BEST_EN
    output logic [13:0] best_ms,
`endif
    output logic        done
);

    localparam int unsigned CNT_W = 14;
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned DLY_W = $clog2(BASE_DELAY_MS + 2048);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MS);
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_EARLY,
        S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic               led_go_q, early_q, timeout_q, done_q;
`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0]   best_q, best_d;
`endif

    // State, counters and registered state-decode flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            led_go_q  <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef REACTION_BEST_EN
            best_q    <= MAX_CNT;
`endif
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            led_go_q  <= (state_d == S_GO);
            early_q   <= (state_d == S_EARLY);
            timeout_q <= (state_d == S_TIMEOUT);
            done_q    <= (state_d == S_DONE);
`ifdef REACTION_BEST_EN
            best_q    <= best_d;
`endif
        end
    end

    // Next-state logic; stop always wins over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        cnt_d   = cnt_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
`ifdef REACTION_BEST_EN
        best_d  = best_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_WAIT;
                    delay_d = DLY_W'(BASE_DELAY_MS) + DLY_W'(lfsr_q[10:0]);
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_EARLY;
                end else if (tick) begin
                    if (delay_q <= DLY_W'(1)) begin
                        state_d = S_GO;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            S_GO: begin
                if (stop) begin
                    state_d = S_DONE;
`ifdef REACTION_BEST_EN
                    if (cnt_q < best_q) best_d = cnt_q;
`endif
                end else if (tick) begin
                    if (cnt_q >= MAX_CNT) begin
                        state_d = S_TIMEOUT;
                        cnt_d   = MAX_CNT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign led_go   = led_go_q;
    assign ms_count = cnt_q;
    assign early    = early_q;
    assign timeout  = timeout_q;
    assign done     = done_q;
`ifdef REACTION_BEST_EN
    assign best_ms  = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer; predicts the random delay from its own LFSR model.
module tb_reaction_timer;

    localparam int unsigned BASE = 1000;
    localparam int unsigned MAXC = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        led_go, early, timeout, done;
    logic [13:0] ms_count;
`ifdef REACTION_BEST_EN
    logic [13:0] best_ms;
`endif

    int total = 0;
    int bad = 0;
    int dly = 0;
    logic [15:0] lfsr_m;

    reaction_timer #(.BASE_DELAY_MS(BASE), .MAX_MS(MAXC)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .led_go(led_go), .ms_count(ms_count), .early(early), .timeout(timeout),
`ifdef REACTION_BEST_EN
        .best_ms(best_ms),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: seed 16'hACE1, taps 16,15,13,4, one step per clock.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[14] ^ lfsr_m[12] ^ lfsr_m[3]};
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic p);
        @(negedge clk);
        tick = t; start = s; stop = p;
        if (s) dly = int'(BASE) + int'(lfsr_m[10:0]);
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic round_to_go(input string tag);
        cyc(1'b0, 1'b1, 1'b0);
        chk({tag, "_cleared"}, int'(ms_count), 0);
        chk({tag, "_wait_led"}, int'(led_go), 0);
        ticks(dly - 1);
        chk({tag, "_pre_go"}, int'(led_go), 0);
        ticks(1);
        chk({tag, "_go"}, int'(led_go), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=expired expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", int'(led_go), 0);
        chk("rst_cnt", int'(ms_count), 0);
        chk("rst_flags", int'({early, timeout, done}), 0);
`ifdef REACTION_BEST_EN
        chk("rst_best", int'(best_ms), 9999);
`endif
        @(negedge clk); rst = 1'b0;

        // Round of 400 ms; start during GO must be ignored.
        round_to_go("r400");
        ticks(400);
        cyc(1'b0, 1'b1, 1'b0);
        chk("go_start_ign", int'(led_go), 1);
        chk("go_start_cnt", int'(ms_count), 400);
        cyc(1'b0, 1'b0, 1'b1);
        chk("r400_done", int'(done), 1);
        chk("r400_cnt", int'(ms_count), 400);
        chk("r400_led", int'(led_go), 0);
`ifdef REACTION_BEST_EN
        chk("best_400", int'(best_ms), 400);
`endif

        // Round of 250 ms; stop in DONE ignored.
        round_to_go("r250");
        ticks(250);
        cyc(1'b0, 1'b0, 1'b1);
        chk("r250_done", int'(done), 1);
        chk("r250_cnt", int'(ms_count), 250);
        cyc(1'b0, 1'b0, 1'b1);
        chk("done_stop_ign", int'({done, ms_count}), int'({1'b1, 14'd250}));
`ifdef REACTION_BEST_EN
        chk("best_250", int'(best_ms), 250);
`endif

        // False start at tick 500 of WAIT, stop beats the same-cycle tick.
        cyc(1'b0, 1'b1, 1'b0);
        ticks(499);
        cyc(1'b0, 1'b1, 1'b0);
        chk("wait_start_ign", int'({led_go, early, done}), 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("early_flag", int'(early), 1);
        chk("early_led", int'(led_go), 0);
        chk("early_cnt", int'(ms_count), 0);
        chk("early_done", int'(done), 0);
`ifdef REACTION_BEST_EN
        chk("best_early", int'(best_ms), 250);
`endif

        // Round of 300 ms; best unchanged.
        round_to_go("r300");
        ticks(300);
        cyc(1'b0, 1'b0, 1'b1);
        chk("r300_cnt", int'(ms_count), 300);
        chk("r300_early_clr", int'(early), 0);
`ifdef REACTION_BEST_EN
        chk("best_300", int'(best_ms), 250);
`endif

        // Stop and tick together at 42 ms: that tick is not counted.
        round_to_go("r42");
        ticks(42);
        cyc(1'b1, 1'b0, 1'b1);
        chk("r42_done", int'(done), 1);
        chk("r42_cnt", int'(ms_count), 42);

        // Asynchronous reset in GO at 300 ms.
        round_to_go("rrst");
        ticks(300);
        chk("rrst_pre", int'(ms_count), 300);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", int'(led_go), 0);
        chk("arst_cnt", int'(ms_count), 0);
        chk("arst_flags", int'({early, timeout, done}), 0);
`ifdef REACTION_BEST_EN
        chk("arst_best", int'(best_ms), 9999);
`endif
        @(negedge clk); rst = 1'b0;
        round_to_go("rpost");
        ticks(5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rpost_cnt", int'(ms_count), 5);

        // Saturation at MAX_MS then TIMEOUT, no wrap.
        round_to_go("rto");
        ticks(9999);
        chk("to_at_max", int'(ms_count), 9999);
        chk("to_not_yet", int'(timeout), 0);
        ticks(1);
        chk("to_flag", int'(timeout), 1);
        chk("to_cnt", int'(ms_count), 9999);
        chk("to_led", int'(led_go), 0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1);
        chk("to_hold", int'({timeout, ms_count}), int'({1'b1, 14'd9999}));
        cyc(1'b0, 1'b1, 1'b0);
        chk("to_restart_flag", int'(timeout), 0);
        chk("to_restart_cnt", int'(ms_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
